// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int DEF_REFRESH_INTERVAL = 1560;
  localparam int DEF_TIMEOUT_CYCLES   = 64;
  localparam int ARB_ADDR_W           = 20;
  localparam int ARB_DATA_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    REFRESH,
    ISSUE,
    BUSY,
    RESP
  } arb_state_t;

  // Command captured at grant time; the field widths must match ADDR_W/DATA_W of the top.
  typedef struct packed {
    logic                  wr;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [1:0]            be;
  } hold_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request bit after last_grant, with wrap.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates NUM_REQ host requesters onto one SDRAM controller port and owns the refresh schedule.
// Optional BUSY watchdog (err on timeout) enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int ADDR_W           = ARB_ADDR_W,
  parameter int DATA_W           = ARB_DATA_W,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
`ifdef SDRAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*2-1:0]        req_be,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic                        ctl_valid,
  input  logic                        ctl_ready,
  output logic                        ctl_wr,
  output logic [ADDR_W-1:0]           ctl_addr,
  output logic [DATA_W-1:0]           ctl_wdata,
  output logic [1:0]                  ctl_be,
  input  logic                        ctl_done,
  input  logic [DATA_W-1:0]           ctl_rdata,
  output logic                        ref_req,
  input  logic                        ref_ack
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int RC_W  = $clog2(REFRESH_INTERVAL + 1);

  arb_state_t          state_reg;
  logic [IDX_W-1:0]    last_grant_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [NUM_REQ-1:0]  grant_reg;
  hold_t               hold_reg;
  logic                ctl_valid_reg;
  logic                ref_req_reg;
  logic [NUM_REQ-1:0]  ack_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [RC_W-1:0]     refresh_cnt_reg;
  logic                ref_pending_reg;

  logic                ref_expire;
  logic                ref_due;
  logic                ref_clear;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [1:0]          be_arr    [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    assign be_arr[gi]    = req_be[gi*2 +: 2];
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_reg),
    .onehot     (pick_onehot),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // An expiry in the current cycle already counts as due, so it beats a same-cycle request.
  assign ref_expire = (refresh_cnt_reg == '0);
  assign ref_due    = ref_pending_reg | ref_expire;
  assign ref_clear  = (state_reg == REFRESH) && ref_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_reg <= RC_W'(REFRESH_INTERVAL - 1);
      ref_pending_reg <= 1'b0;
    end else begin
      if (ref_expire) begin
        refresh_cnt_reg <= RC_W'(REFRESH_INTERVAL - 1);
        ref_pending_reg <= 1'b1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg - RC_W'(1);
        if (ref_clear) begin
          ref_pending_reg <= 1'b0;
        end
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] busy_cnt_reg;
  logic            err_reg;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      idx_reg        <= '0;
      grant_reg      <= '0;
      hold_reg       <= '0;
      ctl_valid_reg  <= 1'b0;
      ref_req_reg    <= 1'b0;
      ack_reg        <= '0;
      rdata_reg      <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      busy_cnt_reg   <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      ack_reg <= '0;
      unique case (state_reg)
        IDLE: begin
          if (ctl_ready) begin
            if (ref_due) begin
              ref_req_reg <= 1'b1;
              state_reg   <= REFRESH;
            end else if (pick_any) begin
              idx_reg       <= pick_idx;
              grant_reg     <= pick_onehot;
              hold_reg      <= '{wr:    req_wr[pick_idx],
                                 addr:  addr_arr[pick_idx],
                                 wdata: wdata_arr[pick_idx],
                                 be:    be_arr[pick_idx]};
              ctl_valid_reg <= 1'b1;
              state_reg     <= ISSUE;
            end
          end
        end
        REFRESH: begin
          if (ref_ack) begin
            ref_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        ISSUE: begin
          if (ctl_ready) begin
            ctl_valid_reg <= 1'b0;
            state_reg     <= BUSY;
`ifdef SDRAM_ARB_TIMEOUT_EN
            busy_cnt_reg  <= '0;
`endif
          end
        end
        BUSY: begin
          if (ctl_done) begin
            if (!hold_reg.wr) begin
              rdata_reg <= ctl_rdata;
            end
            ack_reg   <= grant_reg;
            state_reg <= RESP;
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          else if (busy_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
            ack_reg   <= grant_reg;
            state_reg <= RESP;
          end else begin
            busy_cnt_reg <= busy_cnt_reg + TO_W'(1);
          end
`endif
        end
        RESP: begin
          last_grant_reg <= idx_reg;
`ifdef SDRAM_ARB_TIMEOUT_EN
          err_reg        <= 1'b0;
`endif
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack       = ack_reg;
  assign rdata     = rdata_reg;
  assign ctl_valid = ctl_valid_reg;
  assign ctl_wr    = hold_reg.wr;
  assign ctl_addr  = hold_reg.addr;
  assign ctl_wdata = hold_reg.wdata;
  assign ctl_be    = hold_reg.be;
  assign ref_req   = ref_req_reg;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter with a small SDRAM controller responder; REFRESH_INTERVAL=20.
module tb_sdram_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 20;
  localparam int DW = 16;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_wr;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*2-1:0]   req_be;
  logic [NR-1:0]     ack;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              ctl_valid;
  logic              ctl_ready;
  logic              ctl_wr;
  logic [AW-1:0]     ctl_addr;
  logic [DW-1:0]     ctl_wdata;
  logic [1:0]        ctl_be;
  logic              ctl_done;
  logic [DW-1:0]     ctl_rdata;
  logic              ref_req;
  logic              ref_ack;

  sdram_req_arbiter #(
    .NUM_REQ          (NR),
    .ADDR_W           (AW),
    .DATA_W           (DW),
    .REFRESH_INTERVAL (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .ctl_valid (ctl_valid),
    .ctl_ready (ctl_ready),
    .ctl_wr    (ctl_wr),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_be    (ctl_be),
    .ctl_done  (ctl_done),
    .ctl_rdata (ctl_rdata),
    .ref_req   (ref_req),
    .ref_ack   (ref_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    be;
    int            cyc;
  } cmd_rec_t;

  typedef struct {
    logic [NR-1:0] ack;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } ack_rec_t;

  cmd_rec_t cmd_q[$];
  ack_rec_t ack_q[$];

  int checks;
  int errors;
  int cyc;
  int done_delay;
  logic [DW-1:0] model_rdata;
  int done_cyc;
  int ref_rise_cyc;
  int ref_ack_cyc;
  int busy_left;
  int ref_left;
  bit accepted;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller responder: accepts a command, pulses ctl_done after done_delay cycles
  // (0 = never), and acknowledges refresh two cycles after ref_req is seen.
  always @(negedge clk) begin
    ctl_done = 1'b0;
    ref_ack  = 1'b0;
    if (rst) begin
      ctl_ready    = 1'b1;
      accepted     = 1'b0;
      busy_left    = 0;
      ref_left     = 0;
      ref_rise_cyc = -1;
      ref_ack_cyc  = -1;
      done_cyc     = -1;
    end else begin
      if (accepted) begin
        accepted  = 1'b0;
        ctl_ready = 1'b0;
        busy_left = done_delay;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          ctl_done  = 1'b1;
          ctl_rdata = model_rdata;
          ctl_ready = 1'b1;
          done_cyc  = cyc;
        end
      end else if (ctl_valid && ctl_ready) begin
        accepted = 1'b1;
        cmd_q.push_back('{wr: ctl_wr, addr: ctl_addr, wdata: ctl_wdata, be: ctl_be, cyc: cyc});
      end
      if (ref_req && ref_rise_cyc < 0) ref_rise_cyc = cyc;
      if (ref_left > 0) begin
        ref_left--;
        if (ref_left == 0) begin
          ref_ack = 1'b1;
          if (ref_ack_cyc < 0) ref_ack_cyc = cyc;
        end
      end else if (ref_req) begin
        ref_left = 2;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) tick();
    rst = 1'b0;
    cmd_q.delete();
    ack_q.delete();
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [1:0] be);
    req_wr[i]             = wr;
    req_addr[i*AW +: AW]  = addr;
    req_wdata[i*DW +: DW] = wdata;
    req_be[i*2 +: 2]      = be;
  endtask

  task automatic wait_acks(input int n, input bit drop, input int max_cyc);
    int got;
    int waited;
    got = 0;
    waited = 0;
    while (got < n && waited < max_cyc) begin
      tick();
      waited++;
      if (ack != '0) begin
        ack_q.push_back('{ack: ack, rdata: rdata, err: err, cyc: cyc});
        $display("ack %b rdata 0x%h err %0d cyc %0d", ack, rdata, err, cyc);
        got++;
        if (drop) req = req & ~ack;
      end
    end
    check("ack_count", got, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    done_delay  = 5;
    model_rdata = '0;
    ctl_rdata   = '0;
    req         = '0;
    req_wr      = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_be      = '0;
    rst         = 1'b1;

    // Reset state
    do_reset();
    check("rst_ack", ack, 0);
    check("rst_ctl_valid", ctl_valid, 0);
    check("rst_ref_req", ref_req, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ctl_addr", ctl_addr, 0);

    // Read from requester 0
    done_delay  = 5;
    model_rdata = 16'hBEEF;
    set_req(0, 1'b0, 20'h00123, 16'h0000, 2'b11);
    req = 2'b01;
    tick();
    check("rd_issue_latency", ctl_valid, 1);
    check("rd_ctl_addr", ctl_addr, 20'h00123);
    check("rd_ctl_wr", ctl_wr, 0);
    wait_acks(1, 1'b1, 50);
    if (ack_q.size() >= 1) begin
      check("rd_ack", ack_q[0].ack, 2'b01);
      check("rd_rdata", ack_q[0].rdata, 16'hBEEF);
      check("rd_err", ack_q[0].err, 0);
      check("rd_ack_latency", ack_q[0].cyc - done_cyc, 1);
    end
    tick();
    check("rd_ack_one_cycle", ack, 0);

    // Round robin with both requesters held
    do_reset();
    done_delay = 1;
    set_req(0, 1'b0, 20'h00AAA, 16'h0000, 2'b11);
    set_req(1, 1'b0, 20'h00BBB, 16'h0000, 2'b11);
    req = 2'b11;
    wait_acks(4, 1'b0, 200);
    req = 2'b00;
    if (ack_q.size() >= 4) begin
      check("rr_grant0", ack_q[0].ack, 2'b01);
      check("rr_grant1", ack_q[1].ack, 2'b10);
      check("rr_grant2", ack_q[2].ack, 2'b01);
      check("rr_grant3", ack_q[3].ack, 2'b10);
    end
    if (cmd_q.size() >= 2) begin
      check("rr_addr0", cmd_q[0].addr, 20'h00AAA);
      check("rr_addr1", cmd_q[1].addr, 20'h00BBB);
    end

    // Write from requester 1
    do_reset();
    done_delay = 3;
    set_req(1, 1'b1, 20'h04567, 16'hA5C3, 2'b10);
    req = 2'b10;
    wait_acks(1, 1'b1, 50);
    if (cmd_q.size() >= 1) begin
      check("wr_ctl_wr", cmd_q[0].wr, 1);
      check("wr_ctl_wdata", cmd_q[0].wdata, 16'hA5C3);
      check("wr_ctl_be", cmd_q[0].be, 2'b10);
      check("wr_ctl_addr", cmd_q[0].addr, 20'h04567);
    end
    if (ack_q.size() >= 1) check("wr_ack", ack_q[0].ack, 2'b10);

    // Timer expires during BUSY: refresh waits for RESP, pending req waits for ref_ack
    do_reset();
    done_delay = 25;
    set_req(0, 1'b0, 20'h00111, 16'h0000, 2'b11);
    set_req(1, 1'b0, 20'h00222, 16'h0000, 2'b11);
    req = 2'b11;
    wait_acks(2, 1'b1, 300);
    if (ack_q.size() >= 2 && cmd_q.size() >= 2) begin
      check("busyref_first_ack", ack_q[0].ack, 2'b01);
      check("busyref_ref_after_resp", ref_rise_cyc, ack_q[0].cyc + 2);
      check("busyref_grant_after_refack", cmd_q[1].cyc, ref_ack_cyc + 2);
      check("busyref_second_ack", ack_q[1].ack, 2'b10);
    end

    // Refresh expiry coincident with a new request in IDLE
    do_reset();
    done_delay = 2;
    set_req(0, 1'b0, 20'h00333, 16'h0000, 2'b11);
    while (cyc < 19) tick();
    req = 2'b01;
    tick();
    check("tie_ref_req", ref_req, 1);
    check("tie_ctl_valid", ctl_valid, 0);
    wait_acks(1, 1'b1, 60);
    check("tie_ref_rise_cyc", ref_rise_cyc, 20);
    if (cmd_q.size() >= 1) check("tie_issue_after_refack", cmd_q[0].cyc, ref_ack_cyc + 2);

    // Reset asserted while BUSY aborts the access
    do_reset();
    done_delay = 25;
    set_req(0, 1'b0, 20'h00444, 16'h0000, 2'b11);
    req = 2'b01;
    repeat (5) tick();
    check("abort_in_busy", ctl_valid, 0);
    rst = 1'b1;
    req = 2'b00;
    tick();
    check("abort_ctl_valid", ctl_valid, 0);
    check("abort_ack", ack, 0);
    check("abort_ref_req", ref_req, 0);
    tick();
    rst = 1'b0;
    cmd_q.delete();
    ack_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_ack", ack, 0);
    end
    done_delay  = 2;
    model_rdata = 16'h1234;
    set_req(0, 1'b0, 20'h00055, 16'h0000, 2'b11);
    req = 2'b01;
    tick();
    check("abort_idle_issue", ctl_valid, 1);
    wait_acks(1, 1'b1, 50);
    if (ack_q.size() >= 1) begin
      check("abort_new_ack", ack_q[0].ack, 2'b01);
      check("abort_new_rdata", ack_q[0].rdata, 16'h1234);
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Watchdog: no ctl_done forces an error completion after 64 BUSY cycles
    ack_q.delete();
    cmd_q.delete();
    repeat (3) tick();
    done_delay = 0;
    set_req(0, 1'b0, 20'h00666, 16'h0000, 2'b11);
    req = 2'b01;
    wait_acks(1, 1'b1, 200);
    if (ack_q.size() >= 1 && cmd_q.size() >= 1) begin
      check("to_ack", ack_q[0].ack, 2'b01);
      check("to_err", ack_q[0].err, 1);
      check("to_rdata", ack_q[0].rdata, 0);
      check("to_cycles", ack_q[0].cyc, cmd_q[0].cyc + 65);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
